// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  // ARB: core has priority. BURST: memory is locked to an in-flight DMA burst.
  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Width of both starvation counters; holds max wait values 1..15.
  localparam int WAIT_CNT_W = 4;

  // Words are 8 bytes; any nonzero low address bit is a misaligned access.
  function automatic logic is_misaligned(input logic [2:0] addr_lo);
    return |addr_lo;
  endfunction

endpackage

// File: rtl/dmem_arbiter_sat_wait_counter.sv
// Saturating wait counter: counts consecutive stalled cycles of one requester
// and flags when the tolerated number of stalls has been reached.
module sat_wait_counter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_VAL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);

  localparam logic [WAIT_CNT_W-1:0] MAX_C = WAIT_CNT_W'(MAX_VAL);

  logic [WAIT_CNT_W-1:0] r_cnt;

  // Clear wins over increment; increment stops at MAX_C.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX_C)) begin
      r_cnt <= r_cnt + WAIT_CNT_W'(1);
    end
  end

  assign o_at_max = (r_cnt == MAX_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter in front of the single-port data memory: shares it between the
// core MEM-stage port and the loader/DMA port. Core normally wins; a started
// DMA burst locks the memory until its last beat, and two saturating wait
// counters bound starvation of either side.
//
// Handshake: a requester raises *_req with addr/we/wdata stable and holds
// them until the cycle its *_gnt is 1. A grant means the access is performed
// in that same cycle (reads return data combinationally, writes commit at the
// next rising edge). There is no separate ready; *_req & *_gnt is the transfer.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int XLEN          = 64,
  parameter int CORE_MAX_WAIT = 4,
  parameter int DMA_MAX_WAIT  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  // core port
  input  logic            c_req,
  input  logic            c_we,
  input  logic [XLEN-1:0] c_addr,
  input  logic [XLEN-1:0] c_wdata,
  output logic            c_gnt,
  output logic            c_stall,
  output logic [XLEN-1:0] c_rdata,
  // DMA port
  input  logic            d_req,
  input  logic            d_we,
  input  logic            d_last,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_gnt,
  output logic [XLEN-1:0] d_rdata,
  // memory side
  output logic            mem_we,
  output logic [XLEN-1:0] mem_a,
  output logic [XLEN-1:0] mem_wd,
  input  logic [XLEN-1:0] mem_rd,
  // status / debug
  output logic            err_misalign,
  output logic            o_dbg_state
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       w_c_gnt;
  logic       w_d_gnt;
  logic       w_c_stall;
  logic       w_c_mis;
  logic       w_d_mis;
  logic       w_core_at_max;
  logic       w_dma_at_max;
  logic       r_err;

  assign w_c_mis   = is_misaligned(c_addr[2:0]);
  assign w_d_mis   = is_misaligned(d_addr[2:0]);
  assign w_c_stall = c_req & ~w_c_gnt;

  // Consecutive core stall cycles; only consulted while in BURST.
  sat_wait_counter #(.MAX_VAL(CORE_MAX_WAIT)) u_core_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_inc    (w_c_stall),
    .i_clr    (w_c_gnt | ~c_req),
    .o_at_max (w_core_at_max)
  );

  // Consecutive DMA wait cycles; only consulted while in ARB.
  sat_wait_counter #(.MAX_VAL(DMA_MAX_WAIT)) u_dma_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_inc    (d_req & ~w_d_gnt),
    .i_clr    (w_d_gnt | ~d_req),
    .o_at_max (w_dma_at_max)
  );

  // State register; reset aborts any burst in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant selection and next state; no grants at all while reset is held.
  always_comb begin
    w_c_gnt     = 1'b0;
    w_d_gnt     = 1'b0;
    w_state_nxt = r_state;
    if (rst_n) begin
      case (r_state)
        ARB: begin
          if (c_req && !(d_req && w_dma_at_max)) begin
            w_c_gnt = 1'b1;
          end else if (d_req) begin
            w_d_gnt = 1'b1;
            if (!d_last) w_state_nxt = BURST;
          end
        end
        BURST: begin
          // A forced core beat or a DMA gap lets the core in without
          // releasing the lock.
          if (c_req && (w_core_at_max || !d_req)) begin
            w_c_gnt = 1'b1;
          end else if (d_req) begin
            w_d_gnt = 1'b1;
            if (d_last) w_state_nxt = ARB;
          end
        end
        default: w_state_nxt = ARB;
      endcase
    end
  end

  // Sticky misalignment flag, set by any granted misaligned access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if ((w_c_gnt && w_c_mis) || (w_d_gnt && w_d_mis)) begin
      r_err <= 1'b1;
    end
  end

  assign c_gnt        = w_c_gnt;
  assign d_gnt        = w_d_gnt;
  assign c_stall      = w_c_stall;
  assign c_rdata      = mem_rd;
  assign d_rdata      = mem_rd;
  // Core drives the address/data bus whenever DMA is not granted.
  assign mem_a        = w_d_gnt ? d_addr  : c_addr;
  assign mem_wd       = w_d_gnt ? d_wdata : c_wdata;
  // Misaligned writes are dropped rather than corrupting a neighbour word.
  assign mem_we       = (w_c_gnt & c_we & ~w_c_mis) | (w_d_gnt & d_we & ~w_d_mis);
  assign err_misalign = r_err;
  assign o_dbg_state  = (r_state == BURST);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by random traffic,
// all checked against a cycle-level reference model of the arbitration rules.
module tb_dmem_arbiter;

  localparam int XLEN     = 64;
  localparam int CORE_MAX = 4;
  localparam int DMA_MAX  = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic            c_req, c_we, c_gnt, c_stall;
  logic [XLEN-1:0] c_addr, c_wdata, c_rdata;
  logic            d_req, d_we, d_last, d_gnt;
  logic [XLEN-1:0] d_addr, d_wdata, d_rdata;
  logic            mem_we;
  logic [XLEN-1:0] mem_a, mem_wd, mem_rd;
  logic            err_misalign, o_dbg_state;

  dmem_arbiter #(.XLEN(XLEN), .CORE_MAX_WAIT(CORE_MAX), .DMA_MAX_WAIT(DMA_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_stall(c_stall), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_last(d_last), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rdata(d_rdata),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .err_misalign(err_misalign), .o_dbg_state(o_dbg_state)
  );

  // ---------------- memory (256 words of 8 bytes) ----------------
  logic [XLEN-1:0] mem [256];
  logic [XLEN-1:0] exp_mem [256];
  logic            mem_load;

  function automatic logic [XLEN-1:0] init_word(input int i);
    if (i == 2) return 64'h0000_0000_DEAD_BEEF;
    return {32'h5A5A_0000 + 32'(i), 32'hC0DE_0000 ^ 32'(i * 7)};
  endfunction

  assign mem_rd = mem[mem_a[10:3]];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (mem_we) begin
      mem[mem_a[10:3]] <= mem_wd;
    end
  end

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Burst lock as a flag, wait counts as plain integers.
  bit m_burst;
  int m_cwait, m_dwait;
  bit m_err;

  task automatic model_reset();
    m_burst = 1'b0;
    m_cwait = 0;
    m_dwait = 0;
    m_err   = 1'b0;
  endtask

  // Last sampled DUT outputs, for directed checks.
  logic obs_c, obs_d, obs_we, obs_err, obs_st;

  // One clock cycle: inputs already driven; compare at negedge, advance model at posedge.
  task automatic step(input string tag);
    logic            ec, ed, ewe, c_mis, d_mis;
    logic [XLEN-1:0] ea, ewd;
    if (!rst_n) model_reset();
    c_mis = (c_addr[2:0] != 3'd0);
    d_mis = (d_addr[2:0] != 3'd0);
    ec = 1'b0;
    ed = 1'b0;
    if (rst_n) begin
      if (!m_burst) begin
        if (c_req && !(d_req && m_dwait >= DMA_MAX)) ec = 1'b1;
        else if (d_req) ed = 1'b1;
      end else begin
        if (c_req && (m_cwait >= CORE_MAX || !d_req)) ec = 1'b1;
        else if (d_req) ed = 1'b1;
      end
    end
    ea  = ed ? d_addr : c_addr;
    ewd = ed ? d_wdata : c_wdata;
    ewe = (ec && c_we && !c_mis) || (ed && d_we && !d_mis);

    @(negedge clk);
    obs_c = c_gnt; obs_d = d_gnt; obs_we = mem_we; obs_err = err_misalign; obs_st = o_dbg_state;
    chk({tag, ".c_gnt"},   64'(c_gnt),        64'(ec));
    chk({tag, ".d_gnt"},   64'(d_gnt),        64'(ed));
    chk({tag, ".c_stall"}, 64'(c_stall),      64'(c_req && !ec));
    chk({tag, ".mem_we"},  64'(mem_we),       64'(ewe));
    chk({tag, ".err"},     64'(err_misalign), 64'(m_err));
    chk({tag, ".state"},   64'(o_dbg_state),  64'(m_burst));
    chk({tag, ".mem_a"},   mem_a,             ea);
    if (ewe) chk({tag, ".mem_wd"}, mem_wd, ewd);
    if (ec)  chk({tag, ".c_rdata"}, c_rdata, exp_mem[c_addr[10:3]]);
    if (ed)  chk({tag, ".d_rdata"}, d_rdata, exp_mem[d_addr[10:3]]);

    @(posedge clk);
    if (rst_n) begin
      if (ed) m_burst = !d_last;
      m_cwait = (c_req && !ec) ? ((m_cwait < CORE_MAX) ? m_cwait + 1 : CORE_MAX) : 0;
      m_dwait = (d_req && !ed) ? ((m_dwait < DMA_MAX) ? m_dwait + 1 : DMA_MAX) : 0;
      if ((ec && c_mis) || (ed && d_mis)) m_err = 1'b1;
      if (ewe) exp_mem[ea[10:3]] = ewd;
    end else begin
      model_reset();
    end
    #1;
  endtask

  function automatic logic [XLEN-1:0] rand_addr();
    logic [XLEN-1:0] a;
    a = 64'($urandom_range(0, 255)) << 3;
    if ($urandom_range(0, 15) == 0) a[2:0] = 3'($urandom_range(1, 7));
    return a;
  endfunction

  // ---------------- stimulus ----------------
  logic [XLEN-1:0] bw [20];

  initial begin
    int k, gap, cyc, nd, first_d, nc_mid, d_left;

    for (int i = 0; i < 256; i++) exp_mem[i] = init_word(i);
    model_reset();
    rst_n = 1'b0; mem_load = 1'b1;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_last = 1'b0; d_addr = '0; d_wdata = '0;
    #1;

    // Reset: no grants, c_stall follows c_req.
    step("rst0");
    mem_load = 1'b0;
    c_req = 1'b1; d_req = 1'b1;
    step("rst1");
    chk("rst_c_gnt", 64'(obs_c), 64'd0);
    chk("rst_d_gnt", 64'(obs_d), 64'd0);
    c_req = 1'b0; d_req = 1'b0;
    rst_n = 1'b1;
    step("idle");

    // Core read of 0x10.
    c_req = 1'b1; c_we = 1'b0; c_addr = 64'h10;
    step("cread");
    chk("cread_gnt", 64'(obs_c), 64'd1);
    chk("cread_data", c_rdata, 64'h0000_0000_DEAD_BEEF);

    // Both request continuously, single-beat DMA: DMA every 9th cycle.
    d_req = 1'b1; d_we = 1'b0; d_last = 1'b1; d_addr = 64'h20;
    nd = 0; first_d = 0;
    for (int i = 1; i <= 27; i++) begin
      step("prio");
      if (obs_d) begin
        nd++;
        if (first_d == 0) first_d = i;
      end
    end
    chk("prio_dma_count", 64'(nd), 64'd3);
    chk("prio_first_dma", 64'(first_d), 64'd9);

    // 20-beat DMA write burst to 0x100.. with the core requesting throughout.
    for (int i = 0; i < 20; i++) bw[i] = {$urandom, $urandom};
    k = 0; cyc = 0; nc_mid = 0;
    d_we = 1'b1;
    while (k < 20 && cyc < 200) begin
      d_addr = 64'h100 + 64'(k * 8); d_wdata = bw[k]; d_last = (k == 19);
      step("burst");
      if (obs_c && k > 0) nc_mid++;
      if (obs_d) k++;
      cyc++;
    end
    chk("burst_done", 64'(k), 64'd20);
    chk("burst_core_beats", 64'(nc_mid), 64'd4);
    d_req = 1'b0; c_req = 1'b0;
    step("burst_exit");
    chk("burst_exit_state", 64'(obs_st), 64'd0);
    for (int i = 0; i < 20; i++) chk("burst_mem", mem[8'(32 + i)], bw[i]);

    // DMA gap of 2 cycles mid-burst: core takes both, lock held.
    k = 0; gap = 0; cyc = 0;
    d_we = 1'b0; c_we = 1'b0;
    while (k < 6 && cyc < 40) begin
      if (k == 3 && gap < 2) begin
        d_req = 1'b0; c_req = 1'b1; c_addr = 64'h8;
        step("gap");
        chk("gap_c_gnt", 64'(obs_c), 64'd1);
        chk("gap_state", 64'(obs_st), 64'd1);
        gap++;
      end else begin
        c_req = 1'b0; d_req = 1'b1;
        d_addr = 64'h200 + 64'(k * 8); d_last = (k == 5);
        step("gap_burst");
        if (obs_d) k++;
      end
      cyc++;
    end
    chk("gap_done", 64'(k), 64'd6);
    d_req = 1'b0;

    // Misaligned core write: performed as a grant, write dropped, error sticky.
    c_req = 1'b1; c_we = 1'b1; c_addr = 64'h13; c_wdata = 64'h1111_2222_3333_4444;
    step("miswr");
    chk("miswr_gnt", 64'(obs_c), 64'd1);
    chk("miswr_we", 64'(obs_we), 64'd0);
    c_req = 1'b0; c_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("miswr_hold");
      chk("miswr_err", 64'(obs_err), 64'd1);
    end

    // Random traffic.
    d_left = 0;
    for (int i = 0; i < 600; i++) begin
      if (!c_req && $urandom_range(0, 3) != 0) begin
        c_req = 1'b1; c_we = 1'($urandom_range(0, 1));
        c_addr = rand_addr(); c_wdata = {$urandom, $urandom};
      end
      if (d_left == 0 && !d_req && $urandom_range(0, 5) == 0) begin
        d_left = $urandom_range(1, 6);
        d_we = 1'($urandom_range(0, 1));
        d_addr = rand_addr();
      end
      if (d_left > 0 && !d_req && $urandom_range(0, 9) != 0) begin
        d_req = 1'b1; d_last = (d_left == 1); d_wdata = {$urandom, $urandom};
      end
      step("rand");
      if (obs_c) c_req = 1'b0;
      if (obs_d) begin
        d_req = 1'b0; d_left--;
        d_addr = {d_addr[XLEN-1:3] + 61'd1, d_addr[2:0]} & 64'h7FF;
      end
    end
    // Drain whatever burst is still open.
    c_req = 1'b0;
    cyc = 0;
    while (d_left > 0 && cyc < 50) begin
      d_req = 1'b1; d_last = (d_left == 1);
      step("drain");
      if (obs_d) begin
        d_left--;
        d_addr = {d_addr[XLEN-1:3] + 61'd1, d_addr[2:0]} & 64'h7FF;
      end
      cyc++;
    end
    chk("drain_done", 64'(d_left), 64'd0);
    d_req = 1'b0;

    // Reset pulsed during beat 3 of a burst.
    k = 0; cyc = 0;
    d_we = 1'b1;
    while (k < 2 && cyc < 20) begin
      d_req = 1'b1; d_addr = 64'h300 + 64'(k * 8); d_wdata = {$urandom, $urandom}; d_last = 1'b0;
      step("rburst");
      if (obs_d) k++;
      cyc++;
    end
    chk("rburst_beats", 64'(k), 64'd2);
    chk("rburst_state", 64'(obs_st), 64'd1);
    d_addr = 64'h310;
    rst_n = 1'b0;
    step("rburst_rst");
    chk("rburst_rst_d_gnt", 64'(obs_d), 64'd0);
    chk("rburst_rst_we", 64'(obs_we), 64'd0);
    rst_n = 1'b1;
    c_req = 1'b1; c_we = 1'b0; c_addr = 64'h10;
    step("after_rst");
    chk("after_rst_c_gnt", 64'(obs_c), 64'd1);
    chk("after_rst_state", 64'(obs_st), 64'd0);
    chk("after_rst_err", 64'(obs_err), 64'd0);
    c_req = 1'b0; d_req = 1'b0;
    step("final");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port, word-addressed data memory between the pipeline's MEM-stage load/store port and a loader/DMA port that streams program/data images in bursts. Sits directly in front of the data memory and drives its `WE`/`A`/`WD` inputs, returning `RD` to whichever requester holds the grant. Normally the core has priority. A started DMA burst locks the memory until its last beat, and saturating wait counters bound starvation in both directions.

## Interface
Parameters:
- `XLEN`, 64, address/data width
- `CORE_MAX_WAIT`, 4, consecutive core stall cycles tolerated during a DMA burst before one core beat is forced in (1..15)
- `DMA_MAX_WAIT`, 8, consecutive DMA wait cycles tolerated under core priority before one DMA beat is forced in (1..15)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `c_req`, `c_we`  in  1  core access request / write
- `c_addr`, `c_wdata`  in  XLEN  core address / write data
- `c_gnt`  out  1  core access performed this cycle
- `c_stall`  out  1  `c_req & ~c_gnt`, to the hazard unit
- `c_rdata`  out  XLEN  read data, valid when `c_gnt`
- `d_req`, `d_we`, `d_last`  in  1  DMA request / write / final beat of burst
- `d_addr`, `d_wdata`  in  XLEN  DMA address / write data
- `d_gnt`  out  1  DMA beat performed this cycle
- `d_rdata`  out  XLEN  read data, valid when `d_gnt`
- `mem_we`  out  1  to memory `WE`
- `mem_a`, `mem_wd`  out  XLEN  to memory `A`, `WD`
- `mem_rd`  in  XLEN  from memory `RD` (asynchronous read)
- `err_misalign`  out  1  sticky: some granted access had `addr[2:0] != 0`

## Operation
- States: `ARB` (core priority) and `BURST` (locked to DMA).
- Every access completes in its grant cycle. `c_gnt` and `d_gnt` are never both 1. `mem_a`/`mem_wd` mux the granted requester. If neither is granted, they mux the core.
- `mem_we = (c_gnt & c_we) | (d_gnt & d_we)`. A write is suppressed if its address is misaligned.
- `c_rdata` and `d_rdata` both carry `mem_rd` unconditionally and are qualified by their grant.
- ARB:
  - Grant core if `c_req` and not (`d_req` and `dma_wait == DMA_MAX_WAIT`).
  - Otherwise, grant DMA if `d_req`.
  - A DMA grant with `d_last = 0` moves to BURST.
- BURST:
  - Grant core if `c_req` and (`core_wait == CORE_MAX_WAIT` or `!d_req`).
  - Otherwise, grant DMA if `d_req`.
  - A DMA grant with `d_last = 1` returns to ARB.
  - A forced core beat does not leave BURST.
- `core_wait`: increments (saturating at CORE_MAX_WAIT) when `c_stall`; clears on `c_gnt` or when `!c_req`.
- `dma_wait`: same rule using `d_req`/`d_gnt`.
- `err_misalign` sets on any grant with a misaligned address. Only reset clears it.

## Timing
- Grants, `c_stall`, and all `mem_*` outputs are combinational from the requests and the registered state/counters. Read latency is 0 cycles; a write commits at the next rising edge.
- Reset (async assert, sync-to-`clk` release): state = ARB, counters = 0, `err_misalign` = 0.
- While `rst_n` = 0, `c_gnt`, `d_gnt`, and `mem_we` are forced to 0, and `c_stall` = `c_req`.
- Reset asserted mid-burst aborts the burst. The next beat after reset arbitrates in ARB.
- A single-beat DMA (`d_last = 1` on the first grant) never enters BURST.
- Requesters hold address/data/we stable until granted. The arbiter does not register them.

## Structure
- `dmem_arb_pkg`: `arb_state_t` enum {ARB, BURST}, and the wait-counter width constant (4 bits).
- One sub-module, `sat_wait_counter`: parameterised max value, inputs `inc`/`clr`, output `at_max`. It is instantiated twice.

## Test plan
- Core read only (`c_addr = 0x10`, memory holds `0xDEADBEEF`) -> `c_gnt = 1` the same cycle, `c_rdata = 0xDEADBEEF`, `c_stall = 0`.
- Both request continuously in ARB with single-beat DMA -> core granted 8 cycles, DMA granted on cycle 9, pattern repeats; `c_stall = 1` only on DMA cycles.
- 20-beat DMA write burst to `0x100..0x198` while core requests continuously -> DMA gets 4 beats, core gets 1, repeating. BURST exits after the beat with `d_last`, and memory holds all 20 words.
- `d_req` drops for 2 cycles mid-burst while `c_req = 1` -> core granted both cycles, state stays BURST, and the burst resumes afterwards.
- Core write to `0x13` -> `c_gnt = 1`, `mem_we = 0`, `err_misalign` = 1 from the next cycle and sticky until reset.
- `rst_n` pulsed low during beat 3 of a burst -> grants drop to 0 immediately; after release, a core request is granted in the first cycle (ARB).
